time_stopwatch_lap_57: RTL and testbench

- Single-clock, parametrised stopwatch core with an on-chip 1/100 s prescaler, a run/pause/clear state machine and a circular lap/split record writer.
- Drives the display digits (fsec/sec/min) directly.
- Writes captured records to the record register file through write_e/write_addr/data.
- Successor to the dual-clock stopwatch: all logic sits on clk_50m_57, record depth is configurable, and a lap mode (delta since the previous record) is added.

---
 rtl/time_stopwatch_lap_57.sv | 256 +++++++++++++++++++++++++
 tb/tb_time_stopwatch_lap_57.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_stopwatch_lap_57.sv
// -----------------------------------------------------------------------------
// time_stopwatch_lap_57
//   Single-clock stopwatch core: 1/100 s prescaler, IDLE/RUN/PAUSE control,
//   live fsec/sec/min display counters and a circular lap/split record writer.
//
// Parameters
//   TICK_DIV   clk_50m_57 cycles per 1/100 s tick (>= 2)
//   LAP_DEPTH  number of record slots (2 .. 2**ADDR_W)
//   ADDR_W     width of write_addr_57
//   MIN_MAX    last minute value before the time wraps to 00:00.00 (<= 99)
//
// Ports
//   clk_50m_57          system clock, rising edge
//   rst_n_57            asynchronous active-low reset
//   stopwatch_run_e_57  mode enable; low freezes time and discards key pulses
//   key_run_stop_57     level key, rising edge toggles run/pause
//   key_record_57       level key, rising edge captures a record (RUN only)
//   key_rst_57          level key, rising edge clears the stopwatch
//   lap_mode_57         0 = split (absolute), 1 = lap (delta since last record)
//   write_e_57          one-cycle record write strobe
//   write_addr_57       record slot being written
//   record_*_57         record data, valid with write_e_57, held between writes
//   fsec_57/sec_57/min_57  live time
//   running_57          high while in RUN
//   overflow_57         sticky, set when the time wraps past MIN_MAX:59.99
//   rec_count_57        records written since clear, saturating at LAP_DEPTH
// -----------------------------------------------------------------------------
module time_stopwatch_lap_57 #(
  parameter int TICK_DIV  = 500000,
  parameter int LAP_DEPTH = 5,
  parameter int ADDR_W    = 3,
  parameter int MIN_MAX   = 59
) (
  input  logic              clk_50m_57,
  input  logic              rst_n_57,
  input  logic              stopwatch_run_e_57,
  input  logic              key_run_stop_57,
  input  logic              key_record_57,
  input  logic              key_rst_57,
  input  logic              lap_mode_57,
  output logic              write_e_57,
  output logic [ADDR_W-1:0] write_addr_57,
  output logic [6:0]        record_fsec_57,
  output logic [6:0]        record_sec_57,
  output logic [6:0]        record_min_57,
  output logic [6:0]        fsec_57,
  output logic [6:0]        sec_57,
  output logic [6:0]        min_57,
  output logic              running_57,
  output logic              overflow_57,
  output logic [ADDR_W:0]   rec_count_57
);

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAP_DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W + 1)'(LAP_DEPTH);
  localparam logic [6:0]        MIN_LAST  = 7'(MIN_MAX);
  localparam logic [6:0]        MIN_MOD   = 7'(MIN_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t state_q;

  // ---------------------------------------------------------------------------
  // Key conditioning: bit 0 run/stop, bit 1 record, bit 2 clear.
  // key_s1/key_s2 form the synchroniser, key_s3 is the edge register.
  // ---------------------------------------------------------------------------
  logic [2:0] key_s1, key_s2, key_s3;
  logic [2:0] key_pulse;

  // NOTE: every flop, synchroniser stages included, is cleared by the async
  // reset so the block leaves reset in a fully defined state.
  always_ff @(posedge clk_50m_57 or negedge rst_n_57) begin
    if (!rst_n_57) begin
      key_s1 <= '0;
      key_s2 <= '0;
      key_s3 <= '0;
    end else begin
      // NOTE: non-blocking assignments let the three stages shift together on
      // one edge; blocking ones would collapse the chain into a single flop.
      key_s1 <= {key_rst_57, key_record_57, key_run_stop_57};
      key_s2 <= key_s1;
      key_s3 <= key_s2;
    end
  end

  // Pulses are dropped, not deferred, while the mode is disabled.
  assign key_pulse = key_s2 & ~key_s3 & {3{stopwatch_run_e_57}};

  logic pulse_run_stop, pulse_record, pulse_clear;
  assign pulse_run_stop = key_pulse[0];
  assign pulse_record   = key_pulse[1];
  assign pulse_clear    = key_pulse[2];

  // ---------------------------------------------------------------------------
  // Prescaler tick and next-time computation
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0] pre_cnt;
  logic             count_en, tick;
  logic [6:0]       fsec_nxt, sec_nxt, min_nxt;
  logic             wrap;

  assign count_en = (state_q == ST_RUN) && stopwatch_run_e_57;
  assign tick     = count_en && (pre_cnt == PRE_LAST);

  // NOTE: each always_comb output gets a default first so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    fsec_nxt = fsec_57;
    sec_nxt  = sec_57;
    min_nxt  = min_57;
    wrap     = 1'b0;
    if (fsec_57 == 7'd99) begin
      fsec_nxt = '0;
      if (sec_57 == 7'd59) begin
        sec_nxt = '0;
        if (min_57 == MIN_LAST) begin
          min_nxt = '0;
          wrap    = 1'b1;
        end else begin
          min_nxt = min_57 + 7'd1;
        end
      end else begin
        sec_nxt = sec_57 + 7'd1;
      end
    end else begin
      fsec_nxt = fsec_57 + 7'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control state, prescaler and live time
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_50m_57 or negedge rst_n_57) begin
    if (!rst_n_57) begin
      state_q     <= ST_IDLE;
      running_57  <= 1'b0;
      pre_cnt     <= '0;
      fsec_57     <= '0;
      sec_57      <= '0;
      min_57      <= '0;
      overflow_57 <= 1'b0;
    end else if (pulse_clear) begin
      // Clear overrides any run/stop, record or tick in the same cycle.
      state_q     <= ST_IDLE;
      running_57  <= 1'b0;
      pre_cnt     <= '0;
      fsec_57     <= '0;
      sec_57      <= '0;
      min_57      <= '0;
      overflow_57 <= 1'b0;
    end else begin
      // The tick is evaluated on the pre-transition state, so a run/stop that
      // pauses in a tick cycle still lets that tick land.
      if (count_en) begin
        if (tick) begin
          pre_cnt <= '0;
          fsec_57 <= fsec_nxt;
          sec_57  <= sec_nxt;
          min_57  <= min_nxt;
          if (wrap) overflow_57 <= 1'b1;
        end else begin
          pre_cnt <= pre_cnt + PRE_W'(1);
        end
      end

      if (pulse_run_stop) begin
        case (state_q)
          ST_IDLE, ST_PAUSE: begin
            state_q    <= ST_RUN;
            running_57 <= 1'b1;
          end
          ST_RUN: begin
            state_q    <= ST_PAUSE;
            running_57 <= 1'b0;
          end
          default: begin
            state_q    <= ST_IDLE;
            running_57 <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lap delta: captured time minus last capture with mixed-radix borrow.
  // Every intermediate fits in 7 bits because each field result is < 100.
  // ---------------------------------------------------------------------------
  logic [6:0] last_fsec, last_sec, last_min;
  logic [6:0] lap_fsec, lap_sec, lap_min;
  logic       brw_f, brw_s, brw_m;

  always_comb begin
    brw_f    = (fsec_57 < last_fsec);
    lap_fsec = fsec_57 - last_fsec + (brw_f ? 7'd100 : 7'd0);
    brw_s    = (sec_57 < (last_sec + {6'd0, brw_f}));
    lap_sec  = sec_57 - last_sec - {6'd0, brw_f} + (brw_s ? 7'd60 : 7'd0);
    brw_m    = (min_57 < (last_min + {6'd0, brw_s}));
    lap_min  = min_57 - last_min - {6'd0, brw_s} + (brw_m ? MIN_MOD : 7'd0);
  end

  // ---------------------------------------------------------------------------
  // Record writer: data is registered from the pulse cycle's time value and
  // presented with write_e_57 one cycle later.
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] wr_ptr;
  logic              rec_accept;

  assign rec_accept = pulse_record && (state_q == ST_RUN);

  always_ff @(posedge clk_50m_57 or negedge rst_n_57) begin
    if (!rst_n_57) begin
      write_e_57     <= 1'b0;
      write_addr_57  <= '0;
      record_fsec_57 <= '0;
      record_sec_57  <= '0;
      record_min_57  <= '0;
      wr_ptr         <= '0;
      rec_count_57   <= '0;
      last_fsec      <= '0;
      last_sec       <= '0;
      last_min       <= '0;
    end else if (pulse_clear) begin
      // Record data keeps its last value; only addressing and history reset.
      write_e_57    <= 1'b0;
      write_addr_57 <= '0;
      wr_ptr        <= '0;
      rec_count_57  <= '0;
      last_fsec     <= '0;
      last_sec      <= '0;
      last_min      <= '0;
    end else begin
      write_e_57 <= 1'b0;
      if (rec_accept) begin
        write_e_57     <= 1'b1;
        write_addr_57  <= wr_ptr;
        record_fsec_57 <= lap_mode_57 ? lap_fsec : fsec_57;
        record_sec_57  <= lap_mode_57 ? lap_sec  : sec_57;
        record_min_57  <= lap_mode_57 ? lap_min  : min_57;
        last_fsec      <= fsec_57;
        last_sec       <= sec_57;
        last_min       <= min_57;
        wr_ptr         <= (wr_ptr == ADDR_LAST) ? '0 : wr_ptr + ADDR_W'(1);
        if (rec_count_57 != CNT_MAX) rec_count_57 <= rec_count_57 + (ADDR_W + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_time_stopwatch_lap_57.sv
// -----------------------------------------------------------------------------
// tb_time_stopwatch_lap_57
//   Self-checking bench for time_stopwatch_lap_57 (TICK_DIV=4, LAP_DEPTH=5,
//   ADDR_W=3, MIN_MAX=1). A reference model keeps time as a single count of
//   hundredths and derives pulses from the sampled key history; every cycle the
//   full output set is compared against it, plus directed checks at the
//   interesting points (start latency, wrap, lap deltas, pause, collisions).
// -----------------------------------------------------------------------------
module tb_time_stopwatch_lap_57;

  localparam int TICK_DIV  = 4;
  localparam int LAP_DEPTH = 5;
  localparam int ADDR_W    = 3;
  localparam int MIN_MAX   = 1;
  localparam int PERIOD    = (MIN_MAX + 1) * 6000;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;

  logic              clk_50m_57 = 1'b0;
  logic              rst_n_57;
  logic              stopwatch_run_e_57;
  logic              key_run_stop_57;
  logic              key_record_57;
  logic              key_rst_57;
  logic              lap_mode_57;
  logic              write_e_57;
  logic [ADDR_W-1:0] write_addr_57;
  logic [6:0]        record_fsec_57, record_sec_57, record_min_57;
  logic [6:0]        fsec_57, sec_57, min_57;
  logic              running_57;
  logic              overflow_57;
  logic [ADDR_W:0]   rec_count_57;

  time_stopwatch_lap_57 #(
    .TICK_DIV (TICK_DIV),
    .LAP_DEPTH(LAP_DEPTH),
    .ADDR_W   (ADDR_W),
    .MIN_MAX  (MIN_MAX)
  ) dut (
    .clk_50m_57        (clk_50m_57),
    .rst_n_57          (rst_n_57),
    .stopwatch_run_e_57(stopwatch_run_e_57),
    .key_run_stop_57   (key_run_stop_57),
    .key_record_57     (key_record_57),
    .key_rst_57        (key_rst_57),
    .lap_mode_57       (lap_mode_57),
    .write_e_57        (write_e_57),
    .write_addr_57     (write_addr_57),
    .record_fsec_57    (record_fsec_57),
    .record_sec_57     (record_sec_57),
    .record_min_57     (record_min_57),
    .fsec_57           (fsec_57),
    .sec_57            (sec_57),
    .min_57            (min_57),
    .running_57        (running_57),
    .overflow_57       (overflow_57),
    .rec_count_57      (rec_count_57)
  );

  always #5 clk_50m_57 = ~clk_50m_57;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      if (n_fail >= 40) begin
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (time as total hundredths, modulo PERIOD)
  // ---------------------------------------------------------------------------
  int         m_state, m_h, m_pre, m_ovf, m_last, m_ptr, m_cnt;
  int         m_we, m_waddr, m_rec;
  logic [2:0] hist[$];   // sampled {clear, record, run_stop}, oldest first

  function automatic logic [20:0] pack(input int h);
    return {7'(h / 6000), 7'((h / 100) % 60), 7'(h % 100)};
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_h = 0; m_pre = 0; m_ovf = 0; m_last = 0;
    m_ptr = 0; m_cnt = 0; m_we = 0; m_waddr = 0; m_rec = 0;
    hist.delete();
    repeat (3) hist.push_back(3'b000);
  endtask

  // One rising edge with the inputs that were applied before it.
  task automatic model_edge();
    logic [2:0] pl;
    // A key counts as pressed at this edge when it was sampled high two edges
    // ago and low three edges ago.
    pl = hist[1] & ~hist[0] & {3{stopwatch_run_e_57}};
    hist.push_back({key_rst_57, key_record_57, key_run_stop_57});
    void'(hist.pop_front());

    if (pl[2]) begin
      m_state = S_IDLE; m_h = 0; m_pre = 0; m_ovf = 0; m_last = 0;
      m_ptr = 0; m_cnt = 0; m_we = 0; m_waddr = 0;
    end else begin
      m_we = 0;
      if (pl[1] && m_state == S_RUN) begin
        m_we    = 1;
        m_waddr = m_ptr;
        m_rec   = lap_mode_57 ? (((m_h - m_last) % PERIOD) + PERIOD) % PERIOD : m_h;
        m_last  = m_h;
        m_ptr   = (m_ptr + 1) % LAP_DEPTH;
        if (m_cnt < LAP_DEPTH) m_cnt++;
      end
      if (m_state == S_RUN && stopwatch_run_e_57) begin
        m_pre++;
        if (m_pre == TICK_DIV) begin
          m_pre = 0;
          m_h   = (m_h + 1) % PERIOD;
          if (m_h == 0) m_ovf = 1;
        end
      end
      if (pl[0]) m_state = (m_state == S_RUN) ? S_PAUSE : S_RUN;
    end
  endtask

  function automatic logic [63:0] dut_snap();
    return {12'd0, write_e_57, write_addr_57, record_min_57, record_sec_57,
            record_fsec_57, min_57, sec_57, fsec_57, running_57, overflow_57,
            rec_count_57};
  endfunction

  function automatic logic [63:0] exp_snap();
    return {12'd0, 1'(m_we), 3'(m_waddr), pack(m_rec), pack(m_h),
            1'(m_state == S_RUN), 1'(m_ovf), 4'(m_cnt)};
  endfunction

  function automatic logic [20:0] dut_time();
    return {min_57, sec_57, fsec_57};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  int          wr_seen = 0;
  logic [20:0] last_wr = '0;
  int          obs_addr[$];

  task automatic cyc();
    @(posedge clk_50m_57);
    if (!rst_n_57) model_reset();
    else           model_edge();
    #1;
    check("outputs", dut_snap(), exp_snap());
    if (write_e_57) begin
      wr_seen++;
      obs_addr.push_back(int'(write_addr_57));
      last_wr = {record_min_57, record_sec_57, record_fsec_57};
    end
  endtask

  // mask bit 0 run/stop, bit 1 record, bit 2 clear; the pulse lands on the
  // third edge, i.e. at the end of this task.
  task automatic press(input logic [2:0] mask);
    key_run_stop_57 = mask[0];
    key_record_57   = mask[1];
    key_rst_57      = mask[2];
    cyc();
    cyc();
    key_run_stop_57 = 1'b0;
    key_record_57   = 1'b0;
    key_rst_57      = 1'b0;
    cyc();
  endtask

  // Runs until the time has just become target (first cycle after the tick).
  task automatic run_until(input int target);
    for (int i = 0; i < 60000 && m_h != target; i++) cyc();
    check("reach_time", 64'(dut_time()), 64'(pack(target)));
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int exp_addr[7];
    int t_saved, p_saved, wr_before, n;

    exp_addr = '{0, 1, 2, 3, 4, 0, 1};
    rst_n_57 = 1'b0;
    stopwatch_run_e_57 = 1'b1;
    key_run_stop_57 = 1'b0;
    key_record_57   = 1'b0;
    key_rst_57      = 1'b0;
    lap_mode_57     = 1'b0;
    model_reset();

    // Reset and start latency
    repeat (3) cyc();
    check("reset_outputs", dut_snap(), 64'd0);
    rst_n_57 = 1'b1;
    cyc();
    key_run_stop_57 = 1'b1;
    cyc();
    cyc();
    key_run_stop_57 = 1'b0;
    check("run_not_yet", 64'(running_57), 64'd0);
    cyc();
    check("run_rise_3cyc", 64'(running_57), 64'd1);
    repeat (3) cyc();
    check("fsec_before_tick", 64'(fsec_57), 64'd0);
    cyc();
    check("first_tick_4cyc", 64'(fsec_57), 64'd1);
    repeat (396) cyc();
    check("time_1s", 64'(dut_time()), 64'({7'd0, 7'd1, 7'd0}));

    // Circular addressing
    press(3'b100);
    check("clear_idle", 64'(running_57), 64'd0);
    press(3'b001);
    obs_addr.delete();
    for (int i = 0; i < 7; i++) begin
      repeat (10) cyc();
      press(3'b010);
    end
    repeat (2) cyc();
    check("addr_count", 64'(obs_addr.size()), 64'd7);
    for (int i = 0; i < 7 && i < obs_addr.size(); i++)
      check($sformatf("addr_seq[%0d]", i), 64'(obs_addr[i]), 64'(exp_addr[i]));
    check("rec_count_sat", 64'(rec_count_57), 64'(LAP_DEPTH));

    // Lap mode, including a lap across the wrap; overflow stays sticky
    lap_mode_57 = 1'b1;
    press(3'b100);
    press(3'b001);
    run_until(340);
    press(3'b010);
    cyc();
    check("lap1", 64'(last_wr), 64'({7'd0, 7'd3, 7'd40}));
    run_until(1015);
    press(3'b010);
    cyc();
    check("lap2", 64'(last_wr), 64'({7'd0, 7'd6, 7'd75}));
    run_until(11950);
    press(3'b010);
    cyc();
    check("lap3", 64'(last_wr), 64'({7'd1, 7'd49, 7'd35}));
    run_until(20);
    check("overflow_set", 64'(overflow_57), 64'd1);
    press(3'b010);
    cyc();
    check("lap_wrap", 64'(last_wr), 64'({7'd0, 7'd0, 7'd70}));
    repeat (50) cyc();
    check("overflow_sticky", 64'(overflow_57), 64'd1);
    press(3'b100);
    check("clear_overflow", 64'(overflow_57), 64'd0);
    check("clear_time", 64'(dut_time()), 64'd0);
    check("clear_count", 64'(rec_count_57), 64'd0);

    // Pause mid-prescale
    lap_mode_57 = 1'b0;
    press(3'b001);
    run_until(50);
    repeat (3) cyc();
    press(3'b001);
    t_saved = m_h;
    p_saved = m_pre;
    wr_before = wr_seen;
    repeat (1000) cyc();
    check("pause_frozen", 64'(dut_time()), 64'(pack(t_saved)));
    press(3'b010);
    repeat (2) cyc();
    check("pause_no_write", 64'(wr_seen), 64'(wr_before));
    press(3'b001);
    n = 0;
    while (n < 10 && dut_time() == pack(t_saved)) begin
      cyc();
      n++;
    end
    check("resume_partial", 64'(n), 64'(TICK_DIV - p_saved));

    // Collisions
    wr_before = wr_seen;
    press(3'b011);
    cyc();
    check("rec_rs_one_write", 64'(wr_seen), 64'(wr_before + 1));
    check("rec_rs_paused", 64'(running_57), 64'd0);
    press(3'b001);
    wr_before = wr_seen;
    press(3'b110);
    cyc();
    check("rec_clr_no_write", 64'(wr_seen), 64'(wr_before));
    check("rec_clr_idle", 64'(running_57), 64'd0);
    check("rec_clr_time", 64'(dut_time()), 64'd0);

    // Enable low freezes everything
    press(3'b001);
    repeat (10) cyc();
    stopwatch_run_e_57 = 1'b0;
    t_saved = m_h;
    press(3'b001);
    press(3'b100);
    repeat (100) cyc();
    check("disabled_frozen", 64'(dut_time()), 64'(pack(t_saved)));
    check("disabled_running", 64'(running_57), 64'd1);
    stopwatch_run_e_57 = 1'b1;
    repeat (8) cyc();

    // Asynchronous reset mid-RUN
    rst_n_57 = 1'b0;
    #1;
    check("async_reset", dut_snap(), 64'd0);
    repeat (2) cyc();
    rst_n_57 = 1'b1;
    cyc();

    // Randomised stimulus against the model
    press(3'b001);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)   key_run_stop_57 = ~key_run_stop_57;
      if ($urandom_range(0, 5) == 0)   key_record_57   = ~key_record_57;
      if ($urandom_range(0, 63) == 0)  key_rst_57      = ~key_rst_57;
      if ($urandom_range(0, 31) == 0)  lap_mode_57     = ~lap_mode_57;
      if ($urandom_range(0, 199) == 0) stopwatch_run_e_57 = ~stopwatch_run_e_57;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
